ext_mem_arbiter: RTL
====================

EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default NUM_BRAMS (4), number of BRAM requesters.
REQ-002 SHALL have parameter WIDTH_ADDR, default WIDTH_EXT_ADDR (32), external address width.
REQ-003 SHALL have parameter WIDTH_LEN, default WIDTH_EXT_LENGTH (10), burst-length field width.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 I_Req  input  NUM_REQ  per-requester request; held high until matching O_Done.
REQ-007 I_Store  input  NUM_REQ  per-requester direction: 1 = store, 0 = load.
REQ-008 I_Addr  input  NUM_REQ x WIDTH_ADDR  per-requester external start address.
REQ-009 I_Len  input  NUM_REQ x WIDTH_LEN  per-requester word count; 0 encodes 2^WIDTH_LEN.
REQ-010 O_Grant  output  NUM_REQ  one-hot owner of the external I/F; all-zero when idle.
REQ-011 O_Done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-012 O_Ext_Req  output  1  command valid to the external memory I/F.
REQ-013 O_Ext_Store  output  1  latched direction of the current command.
REQ-014 O_Ext_Addr  output  WIDTH_ADDR  latched start address.
REQ-015 O_Ext_Len  output  WIDTH_LEN  latched length field, passed unmodified.
REQ-016 I_Ext_Ack  input  1  external I/F accepts the command.
REQ-017 I_Beat  input  1  one data word transferred on the external I/F this cycle.
REQ-018 O_Busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM SHALL have states IDLE, CMD, XFER, DONE.
REQ-020 IDLE: if any I_Req bit is high, SHALL select a winner by round-robin starting at priority pointer Ptr, latch its Store/Addr/Len, and go to CMD next cycle; otherwise stay in IDLE.
REQ-021 Round-robin: winner = first set I_Req bit at index Ptr, Ptr+1, ... modulo NUM_REQ.
REQ-022 O_Grant SHALL be one-hot on the winner in CMD, XFER and DONE; zero in IDLE.
REQ-023 CMD: O_Ext_Req=1 with latched fields stable; SHALL stay until I_Ext_Ack=1, then go to XFER.
REQ-024 I_Beat SHALL be ignored in IDLE, CMD and DONE.
REQ-025 XFER: beat counter (WIDTH_LEN+1 bits, cleared on CMD entry) SHALL increment on each I_Beat; when the incremented count equals the target length (Len, or 2^WIDTH_LEN if Len=0), go to DONE.
REQ-026 DONE: O_Done[winner]=1 for exactly one cycle; Ptr <= (winner+1) mod NUM_REQ; next state IDLE.
REQ-027 Minimum turnaround: at least one IDLE cycle between consecutive grants; a request present in DONE is arbitrated in the following IDLE.
REQ-028 Deassertion of the owner's I_Req after grant SHALL be ignored; the transfer completes normally.
REQ-029 Changes on I_Addr/I_Len/I_Store after latching SHALL NOT affect O_Ext_* outputs.
REQ-030 Non-owner requests SHALL wait with O_Grant low; no request is dropped.

Reset
REQ-031 While reset=0: state=IDLE, Ptr=0, beat counter=0, latched fields=0; O_Grant=0, O_Done=0, O_Ext_Req=0, O_Ext_Store=0, O_Ext_Addr=0, O_Ext_Len=0, O_Busy=0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately to the reset values; no O_Done is issued for the aborted transfer.

Verification
REQ-033 Single request: I_Req=0001, Addr=0x100, Len=4, Store=0 -> CMD next cycle, O_Ext_Addr=0x100, O_Ext_Len=4; Ack; 4 beats -> O_Done=0001 for one cycle, then IDLE, Ptr=1.
REQ-034 All four requesting continuously with Len=1 -> grant order 0,1,2,3,0; each O_Done one cycle; never two grant bits set.
REQ-035 Len=0 -> DONE only after 1024 beats; 1023 beats leave the FSM in XFER.
REQ-036 Ack held low 10 cycles -> O_Ext_Req held high with fields stable; beats during CMD are not counted.
REQ-037 Owner drops I_Req and changes I_Addr in XFER -> outputs unchanged, O_Done still pulses after Len beats.
REQ-038 reset=0 after 2 of 4 beats -> all outputs zero asynchronously; after release, a fresh request starts from IDLE with Ptr=0.

Source files
------------

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter granting NUM_REQ BRAM requesters exclusive use of one
// external memory command/burst interface.
//
// state | meaning
// IDLE  | no owner; pick winner from ptr, latch its command fields
// CMD   | O_Ext_Req high with latched fields; wait for I_Ext_Ack
// XFER  | count I_Beat until the latched burst length is reached
// DONE  | one-cycle O_Done pulse to owner; advance ptr past owner
module ext_mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_LEN  = 10
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_REQ-1:0]                   I_Req,
    input  logic [NUM_REQ-1:0]                   I_Store,
    input  logic [NUM_REQ-1:0][WIDTH_ADDR-1:0]   I_Addr,
    input  logic [NUM_REQ-1:0][WIDTH_LEN-1:0]    I_Len,
    output logic [NUM_REQ-1:0]                   O_Grant,
    output logic [NUM_REQ-1:0]                   O_Done,
    output logic                                 O_Ext_Req,
    output logic                                 O_Ext_Store,
    output logic [WIDTH_ADDR-1:0]                O_Ext_Addr,
    output logic [WIDTH_LEN-1:0]                 O_Ext_Len,
    input  logic                                 I_Ext_Ack,
    input  logic                                 I_Beat,
    output logic                                 O_Busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH_LEN:0] FULL_BURST = (WIDTH_LEN+1)'(1) << WIDTH_LEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_owner;
    logic [WIDTH_LEN:0]    r_cnt;
    logic                  r_store;
    logic [WIDTH_ADDR-1:0] r_addr;
    logic [WIDTH_LEN-1:0]  r_len;

    logic [PW-1:0]         w_win;
    logic                  w_win_vld;
    logic [PW:0]           w_idx;
    logic [WIDTH_LEN:0]    w_target;
    logic [WIDTH_LEN:0]    w_cnt_inc;
    logic [NUM_REQ-1:0]    w_owner_oh;
    logic                  w_last_beat;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PW+1)'(NUM_REQ);
            end
            if (!w_win_vld && I_Req[w_idx[PW-1:0]]) begin
                w_win_vld = 1'b1;
                w_win     = w_idx[PW-1:0];
            end
        end
    end

    assign w_target    = (r_len == '0) ? FULL_BURST : {1'b0, r_len};
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_last_beat = I_Beat && (w_cnt_inc == w_target);
    assign w_owner_oh  = NUM_REQ'(1) << r_owner;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_win_vld)   w_next = S_CMD;
            S_CMD:   if (I_Ext_Ack)   w_next = S_XFER;
            S_XFER:  if (w_last_beat) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_store <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_owner <= w_win;
                        r_store <= I_Store[w_win];
                        r_addr  <= I_Addr[w_win];
                        r_len   <= I_Len[w_win];
                        r_cnt   <= '0;
                    end
                end
                S_XFER: begin
                    if (I_Beat) r_cnt <= w_cnt_inc;
                end
                S_DONE: begin
                    r_ptr <= (r_owner == PW'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign O_Busy      = (r_state != S_IDLE);
    assign O_Grant     = O_Busy ? w_owner_oh : '0;
    assign O_Done      = (r_state == S_DONE) ? w_owner_oh : '0;
    assign O_Ext_Req   = (r_state == S_CMD);
    assign O_Ext_Store = r_store;
    assign O_Ext_Addr  = r_addr;
    assign O_Ext_Len   = r_len;

endmodule
